flush_controller: RTL and testbench
===================================

// Module: flush_controller
// PURPOSE
//  Parametrised successor to the single-bit FD flusher. Decodes the 3-bit BranchChecker result,
//  drives a per-stage flush vector for a configurable front-end depth, and extends the flush over
//  a multi-cycle window to cover synchronous-IMEM fetch latency. Also registers the redirect target
//  and keeps a saturating flush counter. Sits between BranchChecker (EX) and the IF/FD pipe registers.
// PARAMETERS
//  XLEN          32  width of redirect target / PC
//  NUM_STAGES    1   front-end pipe-register stages to squash (bit 0 = FD, closest to fetch)
//  FLUSH_CYCLES  1   total cycles flush_o[0] stays high per trigger (>=1; 1 = legacy behaviour)
//  CNT_W         16  width of flush_count_o
// PORTS
//  clk            in   1            system clock, rising edge
//  rst            in   1            asynchronous, active-high reset
//  en_i           in   1            1 = decode result_i; 0 = ignore result_i (no new triggers)
//  result_i       in   3            BranchChecker result code
//  target_i       in   XLEN         branch/jump target computed in EX
//  stall_i        in   1            pipeline stall; freezes the flush window countdown
//  clear_cnt_i    in   1            synchronous clear of flush_count_o
//  flush_o        out  NUM_STAGES   per-stage flush, bit i squashes front-end register i
//  busy_o         out  1            flush window still running after the trigger cycle
//  redirect_vld_o out  1            one-cycle pulse, cycle after trigger
//  redirect_pc_o  out  XLEN         last captured target
//  flush_count_o  out  CNT_W        number of triggers since reset/clear, saturating
// BEHAVIOUR
//  - trigger = en_i & (result_i == RES_BR_TAKEN(3'b100) | result_i == RES_JUMP(3'b110)); all other
//    codes never trigger. Combinational decode, no registering of result_i.
//  - Trigger cycle: flush_o = all ones (same-cycle, zero latency, identical to legacy flush).
//  - Window: on trigger, win_cnt <= FLUSH_CYCLES-1. While win_cnt != 0: flush_o = {..0, 1'b1}
//    (only bit 0), busy_o = 1, win_cnt decrements each cycle with stall_i = 0, holds when stall_i = 1.
//  - flush_o = all ones | window bit: trigger cycle OR's with any running window.
//  - Retrigger during window: win_cnt reloads to FLUSH_CYCLES-1 (restart, no accumulation);
//    new target captured; counter increments.
//  - FLUSH_CYCLES == 1: win_cnt never leaves 0, busy_o constant 0.
//  - Flush has priority over stall: flush_o asserted regardless of stall_i.
//  - redirect_pc_o <= target_i on trigger (registered, 1-cycle latency); holds otherwise.
//    redirect_vld_o <= trigger (high exactly one cycle after each trigger; back-to-back triggers
//    give back-to-back pulses).
//  - flush_count_o: +1 per trigger, saturates at all ones (no wrap). clear_cnt_i has priority for
//    the old value: clear & trigger same cycle -> count = 1; clear alone -> 0.
//  - Reset (any time, incl. mid-window): win_cnt, busy_o, redirect_vld_o, redirect_pc_o,
//    flush_count_o = 0 immediately; flush_o = 0 unless a trigger is present combinationally
//    (decode is not gated by rst only via en_i; bench drives en_i=0 during reset).
//  - Window counter width = $clog2(FLUSH_CYCLES) min 1.
// STRUCTURE
//  - Package flush_pkg: RES_BR_TAKEN = 3'b100, RES_JUMP = 3'b110, RES_W = 3, and a function
//    is_flush(result) shared with BranchChecker-side checkers.
//  - One sub-module: sat_counter (parametrised width, inc, sync clear, async reset, saturate),
//    instantiated for flush_count_o. Window counter and decode stay inline.
// TESTING
//  - Legacy: FLUSH_CYCLES=1, NUM_STAGES=1; sweep result_i 0..7 with en_i=1 -> flush_o=1 only for
//    3'b100/3'b110, same cycle; busy_o stays 0; en_i=0 with 3'b100 -> flush_o=0.
//  - Window: FLUSH_CYCLES=3, NUM_STAGES=2; trigger at t0 -> flush_o 2'b11 @t0, 2'b01 @t1,t2,
//    2'b00 @t3; busy_o high t1..t2; redirect_vld_o high @t1 with redirect_pc_o = target @t0.
//  - Stall: same config, trigger t0, stall_i=1 t1..t3 -> flush_o=2'b01 through t5, drops @t6.
//  - Retrigger: trigger t0 (target 0x100) and t1 (0x200) -> window runs to t3 inclusive,
//    redirect pulses t1,t2, redirect_pc_o=0x200 @t2, flush_count_o=2.
//  - Counter: CNT_W=2, 5 triggers -> count 1,2,3,3,3; clear with trigger -> 1; clear alone -> 0.
//  - Reset mid-window: assert rst at t1 of a 3-cycle window -> busy_o, counts, redirect regs 0
//    asynchronously; after release no residual flush_o.

Source files
------------

// File: rtl/flush_pkg.sv
// Shared BranchChecker result encoding and the flush-decode helper.
// The same decode is used by the flush controller and the checkers on the BranchChecker side.
package flush_pkg;

  localparam int RES_W = 3;

  localparam logic [RES_W-1:0] RES_BR_TAKEN = 3'b100;
  localparam logic [RES_W-1:0] RES_JUMP     = 3'b110;

  // A result needs a front-end flush only when it changes control flow.
  function automatic logic is_flush(input logic [RES_W-1:0] result);
    return (result == RES_BR_TAKEN) || (result == RES_JUMP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. It has a synchronous clear and an asynchronous active-high reset.
// The clear only discards the old value. An increment in the same cycle still counts, so the
// counter reads 1 after a clear that arrives together with an increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {WIDTH{1'b1}});

  // Count update: clear first, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? WIDTH'(1) : '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/flush_controller.sv
// Front-end flush controller. It decodes the BranchChecker result and squashes the IF/FD pipe
// registers. In the trigger cycle all stages are flushed with zero latency. Stage 0 (FD) then
// stays flushed for the rest of a FLUSH_CYCLES window, which covers the synchronous-IMEM fetch
// latency. The controller also registers the redirect target and counts flushes.
module flush_controller
  import flush_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_STAGES   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [RES_W-1:0]      result_i,
  input  logic [XLEN-1:0]       target_i,
  input  logic                  stall_i,
  input  logic                  clear_cnt_i,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  busy_o,
  output logic                  redirect_vld_o,
  output logic [XLEN-1:0]       redirect_pc_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  // win_cnt counts the window cycles that remain after the trigger cycle.
  // It is a single bit when FLUSH_CYCLES == 1, and then only ever holds 0.
  localparam int WIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_RELOAD = WIN_W'(FLUSH_CYCLES - 1);

  logic                  w_trigger;
  logic                  w_busy;
  logic [NUM_STAGES-1:0] w_flush_vec;
  logic [WIN_W-1:0]      r_win_cnt;
  logic                  r_redirect_vld;
  logic [XLEN-1:0]       r_redirect_pc;

  // result_i is decoded directly, without a register, so the flush lands in the same cycle.
  assign w_trigger = en_i & is_flush(result_i);
  assign w_busy    = (r_win_cnt != '0);

  // Flush vector: a running window holds FD only, and a trigger ORs in every stage.
  always_comb begin
    w_flush_vec    = '0;
    w_flush_vec[0] = w_busy;
    if (w_trigger) begin
      w_flush_vec = '1;
    end
  end

  // Window countdown: a trigger restarts it, a stall freezes it, otherwise it drains to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
    end else if (w_trigger) begin
      r_win_cnt <= WIN_RELOAD;
    end else if (w_busy && !stall_i) begin
      r_win_cnt <= r_win_cnt - WIN_W'(1);
    end
  end

  // Redirect: pulse one cycle after each trigger and hold the last captured target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_vld <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_redirect_vld <= w_trigger;
      if (w_trigger) begin
        r_redirect_pc <= target_i;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_trigger),
    .i_clr (clear_cnt_i),
    .o_cnt (flush_count_o)
  );

  assign flush_o        = w_flush_vec;
  assign busy_o         = w_busy;
  assign redirect_vld_o = r_redirect_vld;
  assign redirect_pc_o  = r_redirect_pc;

endmodule

// File: tb/tb_flush_controller.sv
// Directed bench for flush_controller.
// u_leg uses the legacy configuration (FLUSH_CYCLES=1, NUM_STAGES=1) with a 2-bit counter.
// u_win uses the windowed configuration (FLUSH_CYCLES=3, NUM_STAGES=2).
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns after that.
module tb_flush_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // legacy instance signals
  logic        leg_rst, leg_en, leg_stall, leg_clr;
  logic [2:0]  leg_res;
  logic [31:0] leg_tgt;
  logic [0:0]  leg_flush;
  logic        leg_busy, leg_vld;
  logic [31:0] leg_pc;
  logic [1:0]  leg_cnt;

  // windowed instance signals
  logic        win_rst, win_en, win_stall, win_clr;
  logic [2:0]  win_res;
  logic [31:0] win_tgt;
  logic [1:0]  win_flush;
  logic        win_busy, win_vld;
  logic [31:0] win_pc;
  logic [15:0] win_cnt;

  flush_controller #(.XLEN(32), .NUM_STAGES(1), .FLUSH_CYCLES(1), .CNT_W(2)) u_leg (
    .clk(clk), .rst(leg_rst), .en_i(leg_en), .result_i(leg_res), .target_i(leg_tgt),
    .stall_i(leg_stall), .clear_cnt_i(leg_clr), .flush_o(leg_flush), .busy_o(leg_busy),
    .redirect_vld_o(leg_vld), .redirect_pc_o(leg_pc), .flush_count_o(leg_cnt)
  );

  flush_controller #(.XLEN(32), .NUM_STAGES(2), .FLUSH_CYCLES(3), .CNT_W(16)) u_win (
    .clk(clk), .rst(win_rst), .en_i(win_en), .result_i(win_res), .target_i(win_tgt),
    .stall_i(win_stall), .clear_cnt_i(win_clr), .flush_o(win_flush), .busy_o(win_busy),
    .redirect_vld_o(win_vld), .redirect_pc_o(win_pc), .flush_count_o(win_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] res;
    logic       exp_flush;
  } leg_vec_t;

  leg_vec_t tbl[9];

  initial begin
    logic prev_exp;
    logic [31:0] prev_tgt;

    for (int i = 0; i < 8; i++) begin
      tbl[i].en        = 1'b1;
      tbl[i].res       = 3'(i);
      tbl[i].exp_flush = (i == 4) || (i == 6);
    end
    tbl[8].en = 1'b0; tbl[8].res = 3'b100; tbl[8].exp_flush = 1'b0;

    leg_rst = 1'b1; leg_en = 1'b0; leg_stall = 1'b0; leg_clr = 1'b0; leg_res = '0; leg_tgt = '0;
    win_rst = 1'b1; win_en = 1'b0; win_stall = 1'b0; win_clr = 1'b0; win_res = '0; win_tgt = '0;
    tick(); tick();
    chk("rst_leg_flush", 64'(leg_flush), 64'd0);
    chk("rst_leg_cnt",   64'(leg_cnt),   64'd0);
    chk("rst_win_flush", 64'(win_flush), 64'd0);
    chk("rst_win_busy",  64'(win_busy),  64'd0);
    chk("rst_win_vld",   64'(win_vld),   64'd0);
    chk("rst_win_pc",    64'(win_pc),    64'd0);
    leg_rst = 1'b0; win_rst = 1'b0;
    tick();

    // ---- legacy sweep (table driven) ----
    prev_exp = 1'b0;
    prev_tgt = 32'h0;
    for (int i = 0; i < 9; i++) begin
      leg_en = tbl[i].en; leg_res = tbl[i].res; leg_tgt = 32'h1000 + 32'(i);
      settle();
      chk($sformatf("leg_flush[%0d]", i), 64'(leg_flush), 64'(tbl[i].exp_flush));
      chk($sformatf("leg_busy[%0d]", i),  64'(leg_busy),  64'd0);
      chk($sformatf("leg_vld[%0d]", i),   64'(leg_vld),   64'(prev_exp));
      if (tbl[i].exp_flush) prev_tgt = leg_tgt;
      prev_exp = tbl[i].exp_flush;
      tick();
    end
    leg_en = 1'b0;
    settle();
    chk("leg_vld_after", 64'(leg_vld), 64'(prev_exp));
    chk("leg_pc_last",   64'(leg_pc),  64'h1006);
    chk("leg_cnt_sweep", 64'(leg_cnt), 64'd2);

    // ---- saturating counter (CNT_W=2) ----
    leg_clr = 1'b1;
    tick();
    leg_clr = 1'b0;
    settle();
    chk("cnt_clear0", 64'(leg_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      leg_en = 1'b1; leg_res = 3'b110;
      tick();
      chk($sformatf("cnt_inc[%0d]", i), 64'(leg_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    leg_clr = 1'b1; leg_en = 1'b1; leg_res = 3'b100;
    tick();
    chk("cnt_clr_trig", 64'(leg_cnt), 64'd1);
    leg_en = 1'b0;
    tick();
    chk("cnt_clr_only", 64'(leg_cnt), 64'd0);
    leg_clr = 1'b0;

    // ---- window: FLUSH_CYCLES=3 ----
    win_en = 1'b1; win_res = 3'b100; win_tgt = 32'hABCD_0010;
    settle();
    chk("win_t0_flush", 64'(win_flush), 64'h3);
    chk("win_t0_busy",  64'(win_busy),  64'd0);
    tick(); win_en = 1'b0; settle();
    chk("win_t1_flush", 64'(win_flush), 64'h1);
    chk("win_t1_busy",  64'(win_busy),  64'd1);
    chk("win_t1_vld",   64'(win_vld),   64'd1);
    chk("win_t1_pc",    64'(win_pc),    64'hABCD_0010);
    tick(); settle();
    chk("win_t2_flush", 64'(win_flush), 64'h1);
    chk("win_t2_busy",  64'(win_busy),  64'd1);
    chk("win_t2_vld",   64'(win_vld),   64'd0);
    tick(); settle();
    chk("win_t3_flush", 64'(win_flush), 64'h0);
    chk("win_t3_busy",  64'(win_busy),  64'd0);
    chk("win_cnt1",     64'(win_cnt),   64'd1);

    // ---- stall freezes the window; stall at t1..t3 ----
    tick();
    win_en = 1'b1; win_res = 3'b110; win_tgt = 32'h40;
    settle();
    chk("stl_t0_flush", 64'(win_flush), 64'h3);
    for (int t = 1; t <= 6; t++) begin
      tick();
      win_en = 1'b0;
      win_stall = (t >= 1 && t <= 3);
      settle();
      chk($sformatf("stl_t%0d_flush", t), 64'(win_flush), (t <= 5) ? 64'h1 : 64'h0);
      chk($sformatf("stl_t%0d_busy", t),  64'(win_busy),  (t <= 5) ? 64'd1 : 64'd0);
    end
    win_stall = 1'b0;

    // ---- a trigger during a stall still flushes all stages ----
    tick();
    win_en = 1'b1; win_res = 3'b100; win_stall = 1'b1;
    settle();
    chk("stl_prio_flush", 64'(win_flush), 64'h3);
    tick();
    win_en = 1'b0; win_stall = 1'b0;
    tick(); tick(); tick();
    settle();
    chk("stl_prio_drain", 64'(win_flush), 64'h0);

    // ---- retrigger restarts the window ----
    win_clr = 1'b1;
    tick();
    win_clr = 1'b0;
    win_en = 1'b1; win_res = 3'b100; win_tgt = 32'h100;
    settle();
    chk("rt_t0_flush", 64'(win_flush), 64'h3);
    chk("rt_t0_cnt",   64'(win_cnt),   64'd0);
    tick();
    win_res = 3'b110; win_tgt = 32'h200;
    settle();
    chk("rt_t1_flush", 64'(win_flush), 64'h3);
    chk("rt_t1_vld",   64'(win_vld),   64'd1);
    chk("rt_t1_pc",    64'(win_pc),    64'h100);
    tick(); win_en = 1'b0; settle();
    chk("rt_t2_flush", 64'(win_flush), 64'h1);
    chk("rt_t2_vld",   64'(win_vld),   64'd1);
    chk("rt_t2_pc",    64'(win_pc),    64'h200);
    chk("rt_t2_cnt",   64'(win_cnt),   64'd2);
    tick(); settle();
    chk("rt_t3_flush", 64'(win_flush), 64'h1);
    chk("rt_t3_vld",   64'(win_vld),   64'd0);
    tick(); settle();
    chk("rt_t4_flush", 64'(win_flush), 64'h0);

    // ---- reset in the middle of a window ----
    tick();
    win_en = 1'b1; win_res = 3'b100; win_tgt = 32'h55;
    tick();
    win_en = 1'b0;
    settle();
    chk("mr_t1_busy", 64'(win_busy), 64'd1);
    win_rst = 1'b1;
    settle();
    chk("mr_busy",  64'(win_busy),  64'd0);
    chk("mr_flush", 64'(win_flush), 64'h0);
    chk("mr_vld",   64'(win_vld),   64'd0);
    chk("mr_pc",    64'(win_pc),    64'd0);
    chk("mr_cnt",   64'(win_cnt),   64'd0);
    tick();
    win_rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      settle();
      chk($sformatf("mr_post%0d_flush", t), 64'(win_flush), 64'h0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
